bpu_update_arbiter: RTL and testbench
=====================================

# bpu_update_arbiter

Sequences the single-ported predictor table (BTB/Tage bank) between front-end prediction lookups and commit-time updates from the FSQ. After reset it sweeps the table to zero while stalling prediction. It then buffers FSQ update requests in a small FIFO and drains them into idle lookup cycles. When the queue is full or an update has starved too long, it forces a one-cycle prediction stall to steal the port. It sits between the FSQ update path and the table write port, and its stall output feeds the BPU stall term alongside the FSQ stall.

## Interface
Parameters:
- DEPTH, 4 — update queue entries; power of two, at least 2.
- IDX_WIDTH, 9 — table index width; the table has 2^IDX_WIDTH rows.
- INFO_WIDTH, 64 — width of the table row write data.
- STARVE_LIMIT, 8 — cycles a pending head may wait before forcing a port steal; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- upd_valid  in  1  FSQ update request valid.
- upd_ready  out  1  update accepted when upd_valid and upd_ready are both high.
- upd_idx  in  IDX_WIDTH  update row index.
- upd_info  in  INFO_WIDTH  update row data.
- lookup_req  in  1  predictor wants to read the table this cycle.
- stall_pred  out  1  forces the BPU to stall, so no lookup occurs this cycle.
- tbl_we  out  1  table write enable.
- tbl_widx  out  IDX_WIDTH  table write index.
- tbl_wdata  out  INFO_WIDTH  table write data.
- init_done  out  1  high once the reset sweep has completed.

## Operation
- The FSM has two states: INIT and RUN. Reset enters INIT.
- INIT:
  - An init counter starts at 0.
  - Each cycle: tbl_we=1, tbl_widx=counter, tbl_wdata=0, stall_pred=1, upd_ready=0, then the counter increments.
  - After the write to index 2^IDX_WIDTH-1 the FSM moves to RUN. The counter wraps to 0 and is unused afterwards.
- RUN, queue mechanics:
  - The queue is a circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - pending = count!=0.
  - upd_ready = (count!=DEPTH). There is no same-cycle bypass of a full queue.
- RUN, port arbitration:
  - force = pending && (starve==STARVE_LIMIT || count==DEPTH). force depends only on registered state, never on lookup_req.
  - stall_pred = force.
  - write = pending && (force || !lookup_req).
  - When write=1: tbl_we=1 and tbl_widx/tbl_wdata are the head entry; the head pops.
- Starve counter:
  - Clears on write or when the queue is empty.
  - Otherwise increments while pending and not written, saturating at STARVE_LIMIT.
- Enqueue and dequeue in the same cycle leave count unchanged. FIFO order is strict.
- squash/redirect have no effect, since updates are architectural. Only rst clears the queue.
- Reset mid-operation (in either state) drops all queued updates and restarts the sweep from index 0.

## Timing
- Reset values: tbl_we=0, tbl_widx=0, tbl_wdata=0, stall_pred=0, upd_ready=0, init_done=0. Outputs take their INIT values in the first cycle after rst deasserts.
- The sweep lasts exactly 2^IDX_WIDTH cycles. init_done rises in the cycle after the last sweep write, the same cycle the FSM enters RUN.
- A new update's earliest table write is the cycle after it is accepted, giving 1-cycle minimum latency.
- Worst-case update latency with continuous lookups: STARVE_LIMIT+1 cycles after the entry reaches the head.
- stall_pred and tbl_we are combinational from registered state plus lookup_req. There is no path from tbl outputs back to the inputs.

## Configuration
- BPU_UPD_MERGE_EN defined:
  - An accepted update whose upd_idx equals the youngest queued entry's index overwrites that entry's data in place, with no new allocation and no count change.
  - Merging is suppressed if that entry is the head and is being popped this cycle; the update allocates normally.
  - When count==DEPTH and the index matches the youngest entry, the update is still accepted (upd_ready=1).
- BPU_UPD_MERGE_EN undefined: every accepted update allocates an entry, and upd_ready follows the base rule.

## Test plan
- IDX_WIDTH=3, release reset → 8 consecutive writes to indices 0..7 with data 0, stall_pred=1 throughout; init_done=1 in cycle 9.
- RUN with lookup_req=0: enqueue idx=5, data=0xAB → next cycle tbl_we=1, tbl_widx=5, tbl_wdata=0xAB; queue empty afterwards.
- lookup_req held at 1, one update queued, STARVE_LIMIT=8 → no writes for 8 cycles, then stall_pred=1 and the write occurs on the 9th cycle.
- lookup_req=1, push 4 updates with DEPTH=4 → upd_ready=0 and stall_pred=1 on the following cycle, head written, upd_ready=1 the next cycle; entries drain in FIFO order.
- Assert rst mid-drain with 3 entries queued → all outputs reset immediately, the sweep restarts at index 0, and the dropped entries are never written.
- BPU_UPD_MERGE_EN: lookup_req=1, enqueue idx=2/data=1 then idx=2/data=7 → count=1, and a single write of idx 2, data 7 when the port frees.

Source files
------------

// File: rtl/bpu_update_arbiter.sv
// -----------------------------------------------------------------------------
// bpu_update_arbiter
//
// Shares the single-ported predictor table between front-end lookups and
// commit-time updates coming from the FSQ. After reset the whole table is
// swept to zero while prediction is stalled. Afterwards, updates are buffered
// in a small FIFO and written into cycles where no lookup is requested. When
// the FIFO is full, or the head entry has waited STARVE_LIMIT cycles, a
// one-cycle prediction stall is forced so that the write can take the port.
//
// Optional feature macro: BPU_UPD_MERGE_EN
//   When defined, an accepted update that targets the same row as the youngest
//   queued entry overwrites that entry's data instead of allocating a new one.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   upd_valid    FSQ update request valid
//   upd_ready    update accepted when upd_valid && upd_ready
//   upd_idx      update row index
//   upd_info     update row data
//   lookup_req   predictor wants the table this cycle
//   stall_pred   forces the BPU to stall (no lookup this cycle)
//   tbl_we       table write enable
//   tbl_widx     table write index
//   tbl_wdata    table write data
//   init_done    high once the reset sweep has completed
// -----------------------------------------------------------------------------
module bpu_update_arbiter #(
    parameter int DEPTH        = 4,
    parameter int IDX_WIDTH    = 9,
    parameter int INFO_WIDTH   = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [IDX_WIDTH-1:0]  upd_idx,
    input  logic [INFO_WIDTH-1:0] upd_info,
    input  logic                  lookup_req,
    output logic                  stall_pred,
    output logic                  tbl_we,
    output logic [IDX_WIDTH-1:0]  tbl_widx,
    output logic [INFO_WIDTH-1:0] tbl_wdata,
    output logic                  init_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  init_cnt_q;
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [STV_W-1:0]      starve_q;

    logic [IDX_WIDTH-1:0]  mem_idx  [DEPTH];
    logic [INFO_WIDTH-1:0] mem_info [DEPTH];

    logic                  run;
    logic                  pending;
    logic                  full;
    logic                  force_steal;
    logic                  do_write;
    logic                  merge_hit;
    logic                  accept;
    logic                  push;
    logic [PTR_W-1:0]      tail_m1;

    // -------------------------------------------------------------------------
    // Arbitration terms: all derived from registered state, plus lookup_req
    // for the opportunistic write. force_steal never looks at lookup_req.
    // -------------------------------------------------------------------------
    assign run         = (state_q == ST_RUN);
    assign pending     = (count_q != '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign force_steal = run && pending &&
                         ((starve_q == STV_W'(STARVE_LIMIT)) || full);
    assign do_write    = run && pending && (force_steal || !lookup_req);
    assign tail_m1     = tail_q - PTR_W'(1);

`ifdef BPU_UPD_MERGE_EN
    // Youngest entry is the head when count==1; if it is popping this cycle
    // the update must allocate a fresh entry instead of merging.
    assign merge_hit = run && pending && (mem_idx[tail_m1] == upd_idx) &&
                       !(do_write && (count_q == CNT_W'(1)));
    assign upd_ready = !rst && run && (!full || merge_hit);
`else
    assign merge_hit = 1'b0;
    assign upd_ready = !rst && run && !full;
`endif

    assign accept    = upd_valid && upd_ready;
    assign push      = accept && !merge_hit;
    assign init_done = run;

    // -------------------------------------------------------------------------
    // Next state and table-port outputs. Outputs are held at zero while rst is
    // asserted so a mid-operation reset quiets the port immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d    = state_q;
        tbl_we     = 1'b0;
        tbl_widx   = '0;
        tbl_wdata  = '0;
        stall_pred = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    tbl_we     = 1'b1;
                    tbl_widx   = init_cnt_q;
                    stall_pred = 1'b1;
                    if (init_cnt_q == '1) state_d = ST_RUN;
                end
                ST_RUN: begin
                    stall_pred = force_steal;
                    if (do_write) begin
                        tbl_we    = 1'b1;
                        tbl_widx  = mem_idx[head_q];
                        tbl_wdata = mem_info[head_q];
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, sweep counter, queue pointers and starvation counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + IDX_WIDTH'(1);

            if (push)     tail_q <= tail_q + PTR_W'(1);
            if (do_write) head_q <= head_q + PTR_W'(1);

            case ({push, do_write})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (do_write || !pending)
                starve_q <= '0;
            else if (starve_q != STV_W'(STARVE_LIMIT))
                starve_q <= starve_q + STV_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Queue storage.
    // -------------------------------------------------------------------------
    // NOTE: the storage array is not reset; validity is tracked entirely by
    // count/head/tail, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx[tail_q]  <= upd_idx;
            mem_info[tail_q] <= upd_info;
        end else if (accept && merge_hit) begin
            mem_info[tail_m1] <= upd_info;
        end
    end

endmodule

// File: tb/tb_bpu_update_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bpu_update_arbiter
//
// Directed bench for bpu_update_arbiter with IDX_WIDTH=3, DEPTH=4,
// STARVE_LIMIT=8. Inputs change 1 time unit after the rising edge; outputs are
// checked 2 time units after the rising edge, once combinational logic has
// settled on the new inputs. Expected values are hand-derived constants.
// The merge scenario is built only when BPU_UPD_MERGE_EN is defined.
// -----------------------------------------------------------------------------
module tb_bpu_update_arbiter;

    localparam int DEPTH        = 4;
    localparam int IDX_WIDTH    = 3;
    localparam int INFO_WIDTH   = 16;
    localparam int STARVE_LIMIT = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  upd_valid;
    logic                  upd_ready;
    logic [IDX_WIDTH-1:0]  upd_idx;
    logic [INFO_WIDTH-1:0] upd_info;
    logic                  lookup_req;
    logic                  stall_pred;
    logic                  tbl_we;
    logic [IDX_WIDTH-1:0]  tbl_widx;
    logic [INFO_WIDTH-1:0] tbl_wdata;
    logic                  init_done;

    int n_cmp = 0;
    int n_err = 0;

    bpu_update_arbiter #(
        .DEPTH       (DEPTH),
        .IDX_WIDTH   (IDX_WIDTH),
        .INFO_WIDTH  (INFO_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_idx   (upd_idx),
        .upd_info  (upd_info),
        .lookup_req(lookup_req),
        .stall_pred(stall_pred),
        .tbl_we    (tbl_we),
        .tbl_widx  (tbl_widx),
        .tbl_wdata (tbl_wdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs may then change).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle on the current inputs.
    task automatic settle();
        #1;
    endtask

    // Check the full idle-in-RUN output set.
    task automatic check_idle(input string tag);
        check({tag, ".we"},    32'(tbl_we),     32'd0);
        check({tag, ".stall"}, 32'(stall_pred), 32'd0);
    endtask

    task automatic check_write(input string tag, input int idx, input int data, input logic stall);
        check({tag, ".we"},    32'(tbl_we),     32'd1);
        check({tag, ".widx"},  32'(tbl_widx),   32'(idx));
        check({tag, ".wdata"}, 32'(tbl_wdata),  32'(data));
        check({tag, ".stall"}, 32'(stall_pred), 32'(stall));
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < (1 << IDX_WIDTH); i++) begin
            settle();
            check_write($sformatf("%s[%0d]", tag, i), i, 0, 1'b1);
            check({tag, ".ready"}, 32'(upd_ready), 32'd0);
            check({tag, ".done"},  32'(init_done), 32'd0);
            tick();
        end
        settle();
        check({tag, ".done_after"},  32'(init_done), 32'd1);
        check({tag, ".ready_after"}, 32'(upd_ready), 32'd1);
        check_idle({tag, ".after"});
    endtask

    initial begin
        rst        = 1'b1;
        upd_valid  = 1'b0;
        upd_idx    = '0;
        upd_info   = '0;
        lookup_req = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #2;
        check("rst.we",    32'(tbl_we),     32'd0);
        check("rst.widx",  32'(tbl_widx),   32'd0);
        check("rst.wdata", 32'(tbl_wdata),  32'd0);
        check("rst.stall", 32'(stall_pred), 32'd0);
        check("rst.ready", 32'(upd_ready),  32'd0);
        check("rst.done",  32'(init_done),  32'd0);

        // ---------------- initial sweep ----------------
        tick();
        rst = 1'b0;
        check_sweep("sweep");

        // ---------------- single update, idle port ----------------
        lookup_req = 1'b0;
        upd_valid  = 1'b1;
        upd_idx    = 3'd5;
        upd_info   = 16'h00AB;
        settle();
        check("single.ready", 32'(upd_ready), 32'd1);
        check_idle("single.pre");
        tick();
        upd_valid = 1'b0;
        settle();
        check_write("single.wr", 5, 'hAB, 1'b0);
        tick();
        settle();
        check_idle("single.empty");

        // ---------------- starvation steal ----------------
        lookup_req = 1'b1;
        upd_valid  = 1'b1;
        upd_idx    = 3'd3;
        upd_info   = 16'h0033;
        tick();
        upd_valid = 1'b0;
        for (int k = 1; k <= STARVE_LIMIT; k++) begin
            settle();
            check_idle($sformatf("starve.wait%0d", k));
            tick();
        end
        settle();
        check_write("starve.steal", 3, 'h33, 1'b1);
        tick();
        settle();
        check_idle("starve.post");

        // ---------------- full queue steal, FIFO order ----------------
        lookup_req = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            upd_valid = 1'b1;
            upd_idx   = 3'(k);
            upd_info  = 16'(k * 'h11);
            settle();
            check($sformatf("full.ready%0d", k), 32'(upd_ready), 32'd1);
            check_idle($sformatf("full.fill%0d", k));
            tick();
        end
        upd_valid = 1'b0;
        settle();
        check("full.ready_full", 32'(upd_ready), 32'd0);
        check_write("full.steal", 1, 'h11, 1'b1);
        tick();
        settle();
        check("full.ready_again", 32'(upd_ready), 32'd1);
        check_idle("full.hold");
        lookup_req = 1'b0;
        settle();
        check_write("full.drain2", 2, 'h22, 1'b0);
        tick();
        settle();
        check_write("full.drain3", 3, 'h33, 1'b0);
        tick();
        settle();
        check_write("full.drain4", 4, 'h44, 1'b0);
        tick();
        settle();
        check_idle("full.empty");

        // ---------------- reset mid-drain ----------------
        lookup_req = 1'b1;
        upd_valid  = 1'b1;
        upd_idx = 3'd6; upd_info = 16'h0066; tick();
        upd_idx = 3'd7; upd_info = 16'h0077; tick();
        upd_idx = 3'd1; upd_info = 16'h0101; tick();
        upd_valid  = 1'b0;
        lookup_req = 1'b0;
        settle();
        check_write("mid.drain", 6, 'h66, 1'b0);
        rst = 1'b1;
        settle();
        check("mid.rst_we",    32'(tbl_we),     32'd0);
        check("mid.rst_widx",  32'(tbl_widx),   32'd0);
        check("mid.rst_wdata", 32'(tbl_wdata),  32'd0);
        check("mid.rst_stall", 32'(stall_pred), 32'd0);
        check("mid.rst_ready", 32'(upd_ready),  32'd0);
        check("mid.rst_done",  32'(init_done),  32'd0);
        tick();
        rst = 1'b0;
        check_sweep("resweep");
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            check_idle($sformatf("mid.dropped%0d", k));
        end

`ifdef BPU_UPD_MERGE_EN
        // ---------------- merge into youngest entry ----------------
        lookup_req = 1'b1;
        upd_valid  = 1'b1;
        upd_idx = 3'd2; upd_info = 16'h0001; tick();
        upd_idx = 3'd2; upd_info = 16'h0007;
        settle();
        check("merge.ready", 32'(upd_ready), 32'd1);
        tick();
        upd_valid  = 1'b0;
        lookup_req = 1'b0;
        settle();
        check_write("merge.wr", 2, 'h7, 1'b0);
        tick();
        settle();
        check_idle("merge.single");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
